// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and helpers for the pipeline hazard controller.
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_E   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;
  localparam logic [1:0] FWD_W   = 2'd3;

  localparam logic [1:0] T_USE_NONE = 2'd3;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  // $0 is hardwired to zero, so a write to it is never a real producer.
  function automatic logic reg_match(input logic we, input logic [4:0] a3, input logic [4:0] a);
    return we && (a3 == a) && (a != 5'd0);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-register view seen by the hazard controller: stage addresses in, stall/forward selects out.
interface hazard_ctrl_if;

  logic [4:0] D_A1, D_A2;
  logic [1:0] T_use_rs_D, T_use_rt_D;
  logic       md_D;
  logic [4:0] E_A1, E_A2, E_A3;
  logic       RegWrite_E;
  logic [1:0] T_new_E;
  logic [4:0] M_A2, M_A3;
  logic       RegWrite_M;
  logic [1:0] T_new_M;
  logic [4:0] W_A3;
  logic       RegWrite_W;
  logic       md_start_E;
  logic       md_type_E;

  logic       stall;
  logic       clr_E;
  logic [1:0] fwd_rs_D, fwd_rt_D;
  logic [1:0] fwd_rs_E, fwd_rt_E;
  logic [1:0] fwd_rt_M;
  logic       md_busy;

  modport master (
    output D_A1, D_A2, T_use_rs_D, T_use_rt_D, md_D,
    output E_A1, E_A2, E_A3, RegWrite_E, T_new_E,
    output M_A2, M_A3, RegWrite_M, T_new_M,
    output W_A3, RegWrite_W, md_start_E, md_type_E,
    input  stall, clr_E, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M, md_busy
  );

  modport slave (
    input  D_A1, D_A2, T_use_rs_D, T_use_rt_D, md_D,
    input  E_A1, E_A2, E_A3, RegWrite_E, T_new_E,
    input  M_A2, M_A3, RegWrite_M, T_new_M,
    input  W_A3, RegWrite_W, md_start_E, md_type_E,
    output stall, clr_E, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M, md_busy
  );

endinterface

// File: rtl/hazard_ctrl_md_busy_cnt.sv
// Mult/div busy countdown; a new start always reloads, even over an unfinished operation.
module md_busy_cnt
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_type,
  output logic o_busy
);

  localparam logic [CNT_W-1:0] LOAD_MULT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] LOAD_DIV  = CNT_W'(DIV_CYCLES);

  md_state_e        r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_cnt_next   = r_cnt;
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_cnt_next   = i_type ? LOAD_DIV : LOAD_MULT;
          w_state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (i_start) begin
          w_cnt_next = i_type ? LOAD_DIV : LOAD_MULT;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
        w_state_next = (w_cnt_next != '0) ? ST_BUSY : ST_IDLE;
      end
      default: begin
        w_cnt_next   = '0;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign o_busy = (r_state == ST_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall, E-register flush and forwarding-select generation for the D/E/M/W pipeline.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave bus
);

  logic [1:0][4:0] w_d_src, w_e_src;
  logic [1:0][1:0] w_d_tuse, w_d_fwd, w_e_fwd;
  logic [1:0]      w_d_hzd;
  logic            w_md_busy;
  logic            w_stall;

  assign w_d_src  = {bus.D_A2, bus.D_A1};
  assign w_d_tuse = {bus.T_use_rt_D, bus.T_use_rs_D};
  assign w_e_src  = {bus.E_A2, bus.E_A1};

  // Each D source stalls if its producer in flight cannot deliver by the time it is used.
  for (genvar gi = 0; gi < 2; gi++) begin : g_dsrc
    logic w_hit_e, w_hit_m, w_hit_w;
    assign w_hit_e = reg_match(bus.RegWrite_E, bus.E_A3, w_d_src[gi]);
    assign w_hit_m = reg_match(bus.RegWrite_M, bus.M_A3, w_d_src[gi]);
    assign w_hit_w = reg_match(bus.RegWrite_W, bus.W_A3, w_d_src[gi]);
    assign w_d_hzd[gi] = (w_hit_e && (w_d_tuse[gi] < bus.T_new_E)) ||
                         (w_hit_m && (w_d_tuse[gi] < bus.T_new_M));
    assign w_d_fwd[gi] = (w_hit_e && bus.T_new_E == 2'd0) ? FWD_E :
                         (w_hit_m && bus.T_new_M == 2'd0) ? FWD_M :
                         w_hit_w                          ? FWD_W : FWD_GRF;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_esrc
    logic w_hit_m, w_hit_w;
    assign w_hit_m = reg_match(bus.RegWrite_M, bus.M_A3, w_e_src[gi]);
    assign w_hit_w = reg_match(bus.RegWrite_W, bus.W_A3, w_e_src[gi]);
    assign w_e_fwd[gi] = (w_hit_m && bus.T_new_M == 2'd0) ? FWD_M :
                         w_hit_w                          ? FWD_W : FWD_GRF;
  end

  md_busy_cnt #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_start (bus.md_start_E),
    .i_type  (bus.md_type_E),
    .o_busy  (w_md_busy)
  );

  assign w_stall = ~reset & ((|w_d_hzd) | (bus.md_D & (w_md_busy | bus.md_start_E)));

  assign bus.stall    = w_stall;
  assign bus.clr_E    = w_stall;
  assign bus.fwd_rs_D = w_d_fwd[0];
  assign bus.fwd_rt_D = w_d_fwd[1];
  assign bus.fwd_rs_E = w_e_fwd[0];
  assign bus.fwd_rt_E = w_e_fwd[1];
  assign bus.fwd_rt_M = reg_match(bus.RegWrite_W, bus.W_A3, bus.M_A2) ? FWD_W : FWD_GRF;
  assign bus.md_busy  = w_md_busy;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random pipeline states vs. a rule-level model.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if u_if ();

  hazard_ctrl #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N),
    .CNT_W       (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  typedef struct {
    logic       rst;
    logic [4:0] d_a1, d_a2;
    logic [1:0] tu_rs, tu_rt;
    logic       md_d;
    logic [4:0] e_a1, e_a2, e_a3;
    logic       we_e;
    logic [1:0] tn_e;
    logic [4:0] m_a2, m_a3;
    logic       we_m;
    logic [1:0] tn_m;
    logic [4:0] w_a3;
    logic       we_w;
    logic       start, typ;
  } stim_t;

  typedef struct {
    string      tag;
    logic       stall, clr;
    logic [1:0] frsd, frtd, frse, frte, frtm;
    logic       busy;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_txn   = 0;
  // Reference time base: md_busy holds while the edge count is below busy_until.
  int   cyc = 0;
  int   busy_until = 0;

  function automatic bit produces(input bit we, input int a3, input int a);
    return we && (a3 == a) && (a != 0);
  endfunction

  function automatic int d_sel(input stim_t s, input int a);
    if (produces(s.we_e, s.e_a3, a) && s.tn_e == 0) return 1;
    if (produces(s.we_m, s.m_a3, a) && s.tn_m == 0) return 2;
    if (produces(s.we_w, s.w_a3, a)) return 3;
    return 0;
  endfunction

  function automatic int e_sel(input stim_t s, input int a);
    if (produces(s.we_m, s.m_a3, a) && s.tn_m == 0) return 2;
    if (produces(s.we_w, s.w_a3, a)) return 3;
    return 0;
  endfunction

  function automatic bit late(input stim_t s, input int a, input int tu);
    return (produces(s.we_e, s.e_a3, a) && tu < s.tn_e) ||
           (produces(s.we_m, s.m_a3, a) && tu < s.tn_m);
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 1'b0, d_a1: 5'd0, d_a2: 5'd0, tu_rs: T_USE_NONE, tu_rt: T_USE_NONE, md_d: 1'b0,
          e_a1: 5'd0, e_a2: 5'd0, e_a3: 5'd0, we_e: 1'b0, tn_e: 2'd0,
          m_a2: 5'd0, m_a3: 5'd0, we_m: 1'b0, tn_m: 2'd0,
          w_a3: 5'd0, we_w: 1'b0, start: 1'b0, typ: 1'b0};
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s = idle();
    s.rst   = ($urandom_range(0, 49) == 0);
    s.d_a1  = 5'($urandom_range(0, 3));
    s.d_a2  = 5'($urandom_range(0, 3));
    s.tu_rs = 2'($urandom_range(0, 3));
    s.tu_rt = 2'($urandom_range(0, 3));
    s.md_d  = 1'($urandom_range(0, 1));
    s.e_a1  = 5'($urandom_range(0, 3));
    s.e_a2  = 5'($urandom_range(0, 3));
    s.e_a3  = 5'($urandom_range(0, 3));
    s.we_e  = 1'($urandom_range(0, 1));
    s.tn_e  = 2'($urandom_range(0, 2));
    s.m_a2  = 5'($urandom_range(0, 3));
    s.m_a3  = 5'($urandom_range(0, 3));
    s.we_m  = 1'($urandom_range(0, 1));
    s.tn_m  = 2'($urandom_range(0, 1));
    s.w_a3  = 5'($urandom_range(0, 3));
    s.we_w  = 1'($urandom_range(0, 1));
    s.start = ($urandom_range(0, 9) == 0);
    s.typ   = 1'($urandom_range(0, 1));
    return s;
  endfunction

  task automatic issue(input stim_t s, input string tag);
    exp_t e;
    bit   busy_now, data_hz, md_hz;
    @(negedge clk);
    reset            = s.rst;
    u_if.D_A1        = s.d_a1;   u_if.D_A2       = s.d_a2;
    u_if.T_use_rs_D  = s.tu_rs;  u_if.T_use_rt_D = s.tu_rt;
    u_if.md_D        = s.md_d;
    u_if.E_A1        = s.e_a1;   u_if.E_A2       = s.e_a2;   u_if.E_A3 = s.e_a3;
    u_if.RegWrite_E  = s.we_e;   u_if.T_new_E    = s.tn_e;
    u_if.M_A2        = s.m_a2;   u_if.M_A3       = s.m_a3;
    u_if.RegWrite_M  = s.we_m;   u_if.T_new_M    = s.tn_m;
    u_if.W_A3        = s.w_a3;   u_if.RegWrite_W = s.we_w;
    u_if.md_start_E  = s.start;  u_if.md_type_E  = s.typ;

    busy_now = (cyc < busy_until);
    data_hz  = late(s, s.d_a1, s.tu_rs) || late(s, s.d_a2, s.tu_rt);
    md_hz    = s.md_d && (busy_now || s.start);
    e.tag    = tag;
    e.stall  = !s.rst && (data_hz || md_hz);
    e.clr    = e.stall;
    e.frsd   = 2'(d_sel(s, s.d_a1));
    e.frtd   = 2'(d_sel(s, s.d_a2));
    e.frse   = 2'(e_sel(s, s.e_a1));
    e.frte   = 2'(e_sel(s, s.e_a2));
    e.frtm   = produces(s.we_w, s.w_a3, s.m_a2) ? 2'd3 : 2'd0;
    e.busy   = busy_now;
    sb_q.push_back(e);

    @(posedge clk);
    cyc++;
    if (s.rst)        busy_until = 0;
    else if (s.start) busy_until = cyc + (s.typ ? DIV_N : MULT_N);
  endtask

  task automatic chk(input string tag, input string what, input logic [1:0] act, input logic [1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s.%s: got %0d, expected %0d (t=%0t)", tag, what, act, exp, $time);
    end
  endtask

  // Monitor: outputs are combinational, so sample mid-cycle once the stimulus has settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk(e.tag, "stall",    {1'b0, u_if.stall},   {1'b0, e.stall});
        chk(e.tag, "clr_E",    {1'b0, u_if.clr_E},   {1'b0, e.clr});
        chk(e.tag, "fwd_rs_D", u_if.fwd_rs_D,        e.frsd);
        chk(e.tag, "fwd_rt_D", u_if.fwd_rt_D,        e.frtd);
        chk(e.tag, "fwd_rs_E", u_if.fwd_rs_E,        e.frse);
        chk(e.tag, "fwd_rt_E", u_if.fwd_rt_E,        e.frte);
        chk(e.tag, "fwd_rt_M", u_if.fwd_rt_M,        e.frtm);
        chk(e.tag, "md_busy",  {1'b0, u_if.md_busy}, {1'b0, e.busy});
        n_txn++;
        $display("[TB] txn %0d %s stall=%0b busy=%0b fwdD=%0d/%0d", n_txn, e.tag,
                 u_if.stall, u_if.md_busy, u_if.fwd_rs_D, u_if.fwd_rt_D);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    s = idle();
    s.rst = 1'b1;
    u_if.D_A1 = '0; u_if.D_A2 = '0; u_if.T_use_rs_D = T_USE_NONE; u_if.T_use_rt_D = T_USE_NONE;
    u_if.md_D = 1'b0; u_if.E_A1 = '0; u_if.E_A2 = '0; u_if.E_A3 = '0; u_if.RegWrite_E = 1'b0;
    u_if.T_new_E = '0; u_if.M_A2 = '0; u_if.M_A3 = '0; u_if.RegWrite_M = 1'b0; u_if.T_new_M = '0;
    u_if.W_A3 = '0; u_if.RegWrite_W = 1'b0; u_if.md_start_E = 1'b0; u_if.md_type_E = 1'b0;
    @(posedge clk);
    issue(s, "reset");
    s.md_d = 1'b1;
    issue(s, "reset_md");

    s = idle();
    s.e_a3 = 5'd8; s.we_e = 1'b1; s.tn_e = 2'd2; s.d_a1 = 5'd8; s.tu_rs = 2'd0;
    issue(s, "loaduse_t2");
    s.tn_e = 2'd1;
    issue(s, "loaduse_t1");
    s.tn_e = 2'd0;
    issue(s, "loaduse_t0");

    s = idle();
    s.we_e = 1'b1; s.we_m = 1'b1; s.we_w = 1'b1; s.tu_rs = 2'd0; s.tu_rt = 2'd0;
    s.tn_e = 2'd2; s.tn_m = 2'd1;
    issue(s, "zero_reg");

    s = idle();
    s.e_a3 = 5'd5; s.m_a3 = 5'd5; s.w_a3 = 5'd5; s.we_e = 1'b1; s.we_m = 1'b1; s.we_w = 1'b1;
    s.d_a2 = 5'd5; s.tu_rt = 2'd0;
    issue(s, "prio_E");
    s.we_e = 1'b0;
    issue(s, "prio_M");
    s.we_m = 1'b0;
    issue(s, "prio_W");

    s = idle();
    s.md_d = 1'b1; s.start = 1'b1; s.typ = 1'b0;
    issue(s, "mult_start");
    s.start = 1'b0;
    repeat (7) issue(s, "mult_busy");

    s = idle();
    s.start = 1'b1; s.typ = 1'b1;
    issue(s, "div_start");
    s.start = 1'b0;
    repeat (3) issue(s, "div_busy");
    s.start = 1'b1; s.typ = 1'b0;
    issue(s, "reload_mult");
    s.start = 1'b0; s.md_d = 1'b1;
    repeat (7) issue(s, "reload_busy");

    s = idle();
    s.start = 1'b1; s.typ = 1'b1;
    issue(s, "div_start2");
    s.start = 1'b0;
    repeat (3) issue(s, "div_busy2");
    s.rst = 1'b1; s.md_d = 1'b1;
    issue(s, "reset_mid");
    s.rst = 1'b0;
    repeat (3) issue(s, "after_reset");

    repeat (500) issue(rand_stim(), "rand");

    repeat (3) @(negedge clk);
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
